instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Producer side of the instruction word that the control decoder consumes. Holds the PC,
//   fetches 32-bit words from instruction memory over a req/ack handshake, and presents them
//   downstream with valid/ready. Computes the next PC from the decoder's Jump/branch result
//   for the accepted instruction. Supplies pc_plus4 as the jal link value.
// PARAMETERS
//   RESET_PC       32'h0000_0000  PC loaded on reset
//   FETCH_TIMEOUT  16             max cycles imem_req may stay unacked before fetch error (>=2)
// PORTS
//   clock         in   1   single clock, all state updates on posedge
//   reset_n       in   1   synchronous, active-low reset
//   imem_req      out  1   fetch request, level, held until imem_ack
//   imem_addr     out  32  fetch address (= pc), word aligned, stable while imem_req=1
//   imem_ack      in   1   memory returns imem_rdata this cycle
//   imem_rdata    in   32  fetched word, sampled only when imem_req && imem_ack
//   instruction   out  32  fetched word presented to the decoder
//   pc            out  32  address of instruction
//   pc_plus4      out  32  pc + 4, mod 2^32
//   instr_valid   out  1   instruction/pc are valid
//   instr_ready   in   1   downstream accepts. Accept = instr_valid && instr_ready
//   Jump          in   2   00 none, 01 jr, 10 j, 11 jal, for the instruction being accepted
//   branch_taken  in   1   branch resolved taken, for the instruction being accepted
//   jr_target     in   32  register value for jr
//   fetch_err     out  1   sticky timeout flag
// BEHAVIOUR
//   Reset (reset_n=0 at posedge): pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0,
//     instruction=0, fetch_err=0, timeout count=0. Late imem_ack after reset is ignored.
//   FSM IDLE -> FETCH (1 cycle after reset release).
//   FETCH: imem_req=1, imem_addr=pc, counter increments each cycle without ack.
//     ack: instruction<=imem_rdata, counter<=0 -> HOLD. instr_valid=1 the cycle after ack.
//     counter reaches FETCH_TIMEOUT-1 with no ack: -> ERR.
//   HOLD: imem_req=0, instr_valid=1. instruction/pc remain stable until accept.
//     Accept: pc<=next_pc, instr_valid<=0 -> FETCH. Throughput: 1 instr per 2 cycles at best.
//   ERR: imem_req=0, instr_valid=0, fetch_err=1. Leave only through reset.
//   next_pc is decided at accept. Priority, highest first:
//     Jump==01 -> {jr_target[31:2],2'b00}
//     Jump[1]  -> {pc_plus4[31:28], instruction[25:0], 2'b00}
//     branch_taken -> pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00}
//     else     -> pc_plus4
//   All adds are 32-bit mod 2^32. pc 0xFFFF_FFFC sequential wraps to 0x0000_0000.
//   Jump/branch_taken are ignored when there is no accept.
// CONFIGURATION
//   IFU_DELAY_SLOT_EN defined: MIPS branch delay slot.
//     Accepting a redirect stores the target in pending_target and sets pending=1.
//     The next fetch is pc_plus4 (the slot). When the slot is accepted, pc<=pending_target
//     and pending=0. Any redirect inputs during the slot are ignored. Reset clears pending.
//   IFU_DELAY_SLOT_EN undefined: no delay slot. The next fetch is next_pc directly.
// TESTING
//   1. Release reset, ack 1 cycle after req with 0x20080005, ready=1 -> imem_addr=0x0,
//      instr_valid rises the cycle after ack, next imem_addr=0x4.
//   2. j 0x08000010 at pc 0x8, Jump=10 on accept -> next imem_addr=0x00000040.
//   3. beq imm 0xFFFE at pc 0x10, branch_taken=1 -> next imem_addr=0x0000000C.
//   4. instr_ready=0 for 5 cycles in HOLD -> instruction/pc stable, imem_req=0, no new fetch.
//   5. No ack for 16 cycles -> fetch_err=1, imem_req=0, held until reset_n=0.
//   6. jr at pc 0x20, jr_target=0x100: with IFU_DELAY_SLOT_EN fetch 0x24 then 0x100;
//      without the macro, fetch 0x100 directly. Also pc 0xFFFFFFFC sequential -> 0x0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC holder and instruction fetcher feeding the control decoder
// Optional feature: define IFU_DELAY_SLOT_EN for a one-instruction branch delay slot.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  Jump,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  output logic        fetch_err
);

  localparam int             CW       = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   seq_pc;
  logic [31:0]   br_off;
  logic [31:0]   next_pc;
  logic          accept;

`ifdef IFU_DELAY_SLOT_EN
  logic          pending_q, pending_d;
  logic [31:0]   pending_target_q, pending_target_d;
  logic          redirect;
  assign redirect = (Jump != 2'b00) || branch_taken;
`endif

  assign seq_pc = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign accept = valid_q && instr_ready;

  // Redirect target for the held instruction, highest-priority source first
  always_comb begin
    next_pc = seq_pc;
    if (Jump == 2'b01) begin
      next_pc = {jr_target[31:2], 2'b00};
    end else if (Jump[1]) begin
      next_pc = {seq_pc[31:28], instr_q[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = seq_pc + br_off;
    end
  end

  // Fetch FSM next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef IFU_DELAY_SLOT_EN
    pending_d        = pending_q;
    pending_target_d = pending_target_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (accept) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_FETCH;
`ifdef IFU_DELAY_SLOT_EN
          // The slot instruction always runs; a redirect is deferred one accept
          if (pending_q) begin
            pc_d      = pending_target_q;
            pending_d = 1'b0;
          end else begin
            pc_d = seq_pc;
            if (redirect) begin
              pending_d        = 1'b1;
              pending_target_d = next_pc;
            end
          end
`else
          pc_d = next_pc;
`endif
        end
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef IFU_DELAY_SLOT_EN
      pending_q        <= 1'b0;
      pending_target_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef IFU_DELAY_SLOT_EN
      pending_q        <= pending_d;
      pending_target_q <= pending_target_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          NDIR     = 10;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [1:0]  Jump = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] jr_target = '0;
  logic        fetch_err;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Jump(Jump), .branch_taken(branch_taken), .jr_target(jr_target),
    .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr_q[$];
  exp_t        exp_instr_q[$];

  // reference model state: address of the instruction in flight or held
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_pend;
  logic [31:0] m_tgt;
  int          fetch_idx;
  int          accept_idx;
  bit          no_ack;

  // directed opening sequence: fetched words and the decoder result at accept
  logic [31:0] d_word[NDIR];
  logic [1:0]  d_jump[NDIR];
  bit          d_br[NDIR];
  logic [31:0] d_jt[NDIR];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // where execution continues after the held instruction, from the ISA rules
  function automatic logic [31:0] model_target(input logic [31:0] cur_pc, input logic [31:0] word,
                                                input logic [1:0] j, input bit br,
                                                input logic [31:0] jt);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = cur_pc + 32'd4;
    off = {{16{word[15]}}, word[15:0]};
    if (j == 2'b01) return jt - (jt % 4);
    if (j[1]) return (p4 & 32'hF000_0000) | ({6'd0, word[25:0]} * 4);
    if (br) return p4 + off * 4;
    return p4;
  endfunction

  // one negedge of memory and downstream behaviour, updating the model
  task automatic step();
    logic [31:0] w;
    logic [31:0] tgt;
    bit          redir;
    if (imem_req && !no_ack && ($urandom_range(0, 2) != 0)) begin
      w = (fetch_idx < NDIR) ? d_word[fetch_idx] : $urandom;
      imem_ack   = 1'b1;
      imem_rdata = w;
      exp_instr_q.push_back('{word: w, addr: m_pc});
      m_instr = w;
      fetch_idx++;
    end else begin
      imem_ack   = imem_req ? 1'b0 : 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    instr_ready  = ($urandom_range(0, 3) != 0);
    Jump         = 2'($urandom_range(0, 3));
    branch_taken = 1'($urandom_range(0, 1));
    jr_target    = $urandom;
    if (accept_idx < NDIR) begin
      Jump         = d_jump[accept_idx];
      branch_taken = d_br[accept_idx];
      jr_target    = d_jt[accept_idx];
    end
    if (instr_valid && instr_ready) begin
      tgt   = model_target(m_pc, m_instr, Jump, branch_taken, jr_target);
      redir = (Jump != 2'b00) || branch_taken;
`ifdef IFU_DELAY_SLOT_EN
      if (m_pend) begin
        m_pc   = m_tgt;
        m_pend = 1'b0;
      end else begin
        if (redir) begin
          m_tgt  = tgt;
          m_pend = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end
`else
      m_pc = redir ? tgt : m_pc + 32'd4;
`endif
      exp_addr_q.push_back(m_pc);
      accept_idx++;
    end
  endtask

  task automatic run_accepts(input int n, input int budget);
    int target;
    target = accept_idx + n;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      step();
      if (accept_idx >= target) return;
    end
    checks++;
    errors++;
    $display("FAIL accept_budget actual=%0d expected=%0d", accept_idx, target);
  endtask

  // monitor: pops expectations when a fetch starts or an instruction is presented
  logic        prev_req;
  logic        prev_valid;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;
  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      prev_req   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (imem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected actual=%h expected=none", imem_addr);
        end else begin
          check32("fetch_addr", imem_addr, exp_addr_q.pop_front());
        end
      end
      if (instr_valid && !prev_valid) begin
        if (exp_instr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL valid_unexpected actual=%h expected=none", instruction);
        end else begin
          exp_t e;
          e = exp_instr_q.pop_front();
          check32("instruction", instruction, e.word);
          check32("instr_pc", pc, e.addr);
          check32("pc_plus4", pc_plus4, e.addr + 32'd4);
        end
      end
      if (instr_valid && prev_valid) begin
        check32("hold_instr", instruction, prev_instr);
        check32("hold_pc", pc, prev_pc);
        check32("hold_req", {31'd0, imem_req}, 32'd0);
      end
      prev_req   = imem_req;
      prev_valid = instr_valid;
      prev_instr = instruction;
      prev_pc    = pc;
    end
  end

  task automatic check_reset_state();
    check32("rst_req", {31'd0, imem_req}, 32'd0);
    check32("rst_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst_instr", instruction, 32'd0);
    check32("rst_err", {31'd0, fetch_err}, 32'd0);
    check32("rst_pc", pc, RESET_PC);
  endtask

  initial begin
    int req_cycles;
    d_word = '{32'h2008_0005, 32'h0800_0002, 32'h0800_0010, 32'h1000_FFFE, 32'h0000_0008,
               32'h0C00_1234, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    d_jump = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
    d_br   = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    d_jt   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0103, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0};
    fetch_idx  = 0;
    accept_idx = 0;
    no_ack     = 1'b0;
    m_pend     = 1'b0;
    m_tgt      = '0;
    m_instr    = '0;

    imem_ack = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state();
    @(negedge clock);
    m_pc = RESET_PC;
    exp_addr_q.push_back(RESET_PC);
    reset_n = 1'b1;
    run_accepts(250, 6000);

    // timeout: start from a held instruction so the next fetch is counted from its first cycle
    for (int c = 0; c < 200 && !instr_valid; c++) begin
      @(negedge clock);
      step();
    end
    no_ack = 1'b1;
    req_cycles = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (fetch_err) break;
      if (imem_req) req_cycles++;
      step();
    end
    check32("timeout_cycles", req_cycles, 32'd16);
    check32("err_set", {31'd0, fetch_err}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      step();
      check32("err_sticky", {31'd0, fetch_err}, 32'd1);
      check32("err_req", {31'd0, imem_req}, 32'd0);
      check32("err_valid", {31'd0, instr_valid}, 32'd0);
    end

    // reset with a stray ack present, then resume normal fetching
    @(negedge clock);
    reset_n  = 1'b0;
    imem_ack = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state();
    @(negedge clock);
    exp_addr_q.delete();
    exp_instr_q.delete();
    m_pc       = RESET_PC;
    m_pend     = 1'b0;
    fetch_idx  = NDIR;
    accept_idx = NDIR;
    no_ack     = 1'b0;
    exp_addr_q.push_back(RESET_PC);
    reset_n = 1'b1;
    run_accepts(30, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
